// File: rtl/ac_motor_svm_dwell_if.sv
// Request/result bundle between the sine generator, the dwell calculator and the PWM sequencer.
// master drives requests and consumes results; slave is the dwell calculator.
interface ac_motor_svm_dwell_if #(
  parameter int BITS = 12,
  parameter int TW   = 15
);
  logic            IN_VALID;
  logic            IN_READY;
  logic [BITS-1:0] U_STR;
  logic [BITS-1:0] SIN_POSITIVE;
  logic [BITS-1:0] SIN_NEGATIVE;
  logic [7:0]      ZSPLIT;
  logic [TW-1:0]   T_0;
  logic [TW-1:0]   T_1;
  logic [TW-1:0]   T_2;
  logic [TW-1:0]   T_7;
  logic            OUT_VALID;
  logic            SAT;

  modport master (
    output IN_VALID, U_STR, SIN_POSITIVE, SIN_NEGATIVE, ZSPLIT,
    input  IN_READY, T_0, T_1, T_2, T_7, OUT_VALID, SAT
  );

  modport slave (
    input  IN_VALID, U_STR, SIN_POSITIVE, SIN_NEGATIVE, ZSPLIT,
    output IN_READY, T_0, T_1, T_2, T_7, OUT_VALID, SAT
  );
endinterface

// File: rtl/ac_motor_svm_dwell.sv
// Space-vector dwell times T_0/T_1/T_2/T_7 with proportional overmodulation limiting.
// 4 cycles to OUT_VALID, 4+TW when limited; IN_READY only in IDLE, requests are never queued.
module ac_motor_svm_dwell #(
  parameter int BITS   = 12,
  parameter int F_CLK  = 100000000,
  parameter int F_TAST = 5000,
  parameter int T_TAST = F_CLK / F_TAST,
  parameter int TW     = 15
) (
  input logic                CLK,
  input logic                RST,
  ac_motor_svm_dwell_if.slave bus
);

  localparam int PW = 2 * BITS;
  localparam int MW = TW + PW;
  localparam int CW = (TW > 1) ? $clog2(TW) : 1;
  localparam logic [TW-1:0] T_C = TW'(T_TAST);

  typedef enum logic [2:0] {IDLE, MUL, SCALE, CHECK, DIV, ZERO} state_t;

  state_t          state;
  logic [BITS-1:0] u_r, sn_r, sp_r;
  logic [7:0]      zs_r;
  logic [PW-1:0]   p1, p2;
  logic [TW-1:0]   t1, t2, tz;
  logic [TW:0]     s_r;
  logic            sat_r;
  logic [TW:0]     rem;
  logic [TW-1:0]   num_lo;
  logic [TW-1:0]   quo;
  logic [CW-1:0]   cnt;

  logic [MW-1:0]   sc1, sc2;
  logic [TW-1:0]   t1_sc, t2_sc;
  logic [TW:0]     s_c;
  logic [2*TW-1:0] num_c;
  logic [TW+1:0]   trial, diff;
  logic            ge;
  logic [TW:0]     rem_n;
  logic [TW-1:0]   q_n;
  logic [TW+7:0]   t7_prod;
  logic [TW-1:0]   t7_c;

  assign sc1   = MW'(T_C) * MW'(p1);
  assign sc2   = MW'(T_C) * MW'(p2);
  assign t1_sc = TW'(sc1 >> PW);
  assign t2_sc = TW'(sc2 >> PW);
  assign s_c   = {1'b0, t1} + {1'b0, t2};
  assign num_c = (2*TW)'(t1) * (2*TW)'(T_C);

  // One restoring step: the partial remainder is always below the divisor, so it fits in TW+1 bits.
  assign trial = {rem, num_lo[TW-1]};
  assign diff  = trial - {1'b0, s_r};
  assign ge    = (trial >= {1'b0, s_r});
  assign rem_n = ge ? (TW+1)'(diff) : (TW+1)'(trial);
  assign q_n   = {quo[TW-2:0], ge};

  assign t7_prod = (TW+8)'(tz) * (TW+8)'(zs_r);
  assign t7_c    = TW'(t7_prod >> 8);

  assign bus.IN_READY = (state == IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      u_r           <= '0;
      sn_r          <= '0;
      sp_r          <= '0;
      zs_r          <= '0;
      p1            <= '0;
      p2            <= '0;
      t1            <= '0;
      t2            <= '0;
      tz            <= '0;
      s_r           <= '0;
      sat_r         <= 1'b0;
      rem           <= '0;
      num_lo        <= '0;
      quo           <= '0;
      cnt           <= '0;
      bus.T_0       <= '0;
      bus.T_1       <= '0;
      bus.T_2       <= '0;
      bus.T_7       <= '0;
      bus.OUT_VALID <= 1'b0;
      bus.SAT       <= 1'b0;
    end else begin
      bus.OUT_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.IN_VALID) begin
            u_r   <= bus.U_STR;
            sn_r  <= bus.SIN_NEGATIVE;
            sp_r  <= bus.SIN_POSITIVE;
            zs_r  <= bus.ZSPLIT;
            state <= MUL;
          end
        end
        MUL: begin
          p1    <= PW'(u_r) * PW'(sn_r);
          p2    <= PW'(u_r) * PW'(sp_r);
          state <= SCALE;
        end
        SCALE: begin
          t1    <= t1_sc;
          t2    <= t2_sc;
          state <= CHECK;
        end
        CHECK: begin
          s_r <= s_c;
          cnt <= '0;
          quo <= '0;
          if (s_c <= {1'b0, T_C}) begin
            tz    <= T_C - s_c[TW-1:0];
            sat_r <= 1'b0;
            state <= ZERO;
          end else begin
            // Scale t1 so the active vectors fill the whole period; t2 takes the remainder.
            sat_r  <= 1'b1;
            rem    <= {1'b0, num_c[2*TW-1:TW]};
            num_lo <= num_c[TW-1:0];
            state  <= DIV;
          end
        end
        DIV: begin
          rem    <= rem_n;
          num_lo <= num_lo << 1;
          quo    <= q_n;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(TW - 1)) begin
            t1    <= q_n;
            t2    <= T_C - q_n;
            tz    <= '0;
            state <= ZERO;
          end
        end
        ZERO: begin
          bus.T_7       <= t7_c;
          bus.T_0       <= tz - t7_c;
          bus.T_1       <= t1;
          bus.T_2       <= t2;
          bus.SAT       <= sat_r;
          bus.OUT_VALID <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_motor_svm_dwell.sv
// Directed bench for ac_motor_svm_dwell: hand-computed dwell times, latency, handshake and reset cases.
module tb_ac_motor_svm_dwell;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  ac_motor_svm_dwell_if bus ();

  ac_motor_svm_dwell dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one request, then count edges after the transfer edge until OUT_VALID is seen.
  task automatic request(input int u, input int sn, input int sp, input int z, output int lat);
    int w;
    w = 0;
    while (!bus.IN_READY && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    bus.U_STR        = 12'(u);
    bus.SIN_NEGATIVE = 12'(sn);
    bus.SIN_POSITIVE = 12'(sp);
    bus.ZSPLIT       = 8'(z);
    bus.IN_VALID     = 1'b1;
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.OUT_VALID && lat < 100);
  endtask

  task automatic expect_res(input string tag, input int lat, input int exp_lat,
                            input int e0, input int e1, input int e2, input int e7, input int esat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_t0"}, bus.T_0, e0);
    check({tag, "_t1"}, bus.T_1, e1);
    check({tag, "_t2"}, bus.T_2, e2);
    check({tag, "_t7"}, bus.T_7, e7);
    check({tag, "_sat"}, bus.SAT, esat);
    check({tag, "_rdy"}, bus.IN_READY, 1);
    @(posedge clk);
    #1;
    check({tag, "_vld_pulse"}, bus.OUT_VALID, 0);
    check({tag, "_hold"}, bus.T_1, e1);
  endtask

  int lat;
  int nvld;
  int last_cyc;
  int nres;
  int hs_u  [3] = '{2048, 2048, 3200};
  int hs_sn [3] = '{2048, 1024, 2621};
  int hs_sp [3] = '{1024, 2048, 2622};
  int hs_z  [3] = '{128, 0, 128};
  int hs_e0 [3] = '{6250, 12500, 0};
  int hs_e1 [3] = '{5000, 2500, 9998};
  int hs_e2 [3] = '{2500, 5000, 10002};
  int hs_e7 [3] = '{6250, 0, 0};
  int hs_seq[5] = '{0, 2, 1, 0, 2};

  initial begin
    bus.IN_VALID     = 1'b0;
    bus.U_STR        = '0;
    bus.SIN_NEGATIVE = '0;
    bus.SIN_POSITIVE = '0;
    bus.ZSPLIT       = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_t0", bus.T_0, 0);
    check("rst_t1", bus.T_1, 0);
    check("rst_t2", bus.T_2, 0);
    check("rst_t7", bus.T_7, 0);
    check("rst_vld", bus.OUT_VALID, 0);
    check("rst_sat", bus.SAT, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rdy", bus.IN_READY, 1);

    request(2048, 2048, 1024, 128, lat);
    expect_res("nom", lat, 4, 6250, 5000, 2500, 6250, 0);

    request(4095, 4095, 4095, 128, lat);
    expect_res("ovm", lat, 19, 0, 10000, 10000, 0, 1);

    request(4095, 4095, 2048, 77, lat);
    expect_res("ovm_asym", lat, 19, 0, 13332, 6668, 0, 1);

    request(2048, 2048, 1024, 0, lat);
    expect_res("z0", lat, 4, 12500, 5000, 2500, 0, 0);

    request(2048, 2048, 1024, 64, lat);
    expect_res("z64", lat, 4, 9375, 5000, 2500, 3125, 0);

    request(2048, 2048, 1024, 255, lat);
    expect_res("z255", lat, 4, 49, 5000, 2500, 12451, 0);

    request(3200, 2621, 2622, 128, lat);
    expect_res("s_eq_t", lat, 4, 0, 9998, 10002, 0, 0);

    // Continuous IN_VALID with data changing every cycle.
    nres = 0;
    last_cyc = 0;
    for (int c = 0; c < 25; c++) begin
      bus.U_STR        = 12'(hs_u[c % 3]);
      bus.SIN_NEGATIVE = 12'(hs_sn[c % 3]);
      bus.SIN_POSITIVE = 12'(hs_sp[c % 3]);
      bus.ZSPLIT       = 8'(hs_z[c % 3]);
      bus.IN_VALID     = 1'b1;
      if (c == 1) check("hs_busy_rdy", bus.IN_READY, 0);
      @(posedge clk);
      #1;
      if (bus.OUT_VALID && nres < 5) begin
        check("hs_t0", bus.T_0, hs_e0[hs_seq[nres]]);
        check("hs_t1", bus.T_1, hs_e1[hs_seq[nres]]);
        check("hs_t2", bus.T_2, hs_e2[hs_seq[nres]]);
        check("hs_t7", bus.T_7, hs_e7[hs_seq[nres]]);
        check("hs_rdy", bus.IN_READY, 1);
        if (nres > 0) check("hs_period", c - last_cyc, 5);
        last_cyc = c;
        nres++;
      end
    end
    bus.IN_VALID = 1'b0;
    check("hs_count", nres, 5);
    @(posedge clk);
    #1;

    // Abort an overmodulated computation while the divider is running.
    bus.U_STR        = 12'd4095;
    bus.SIN_NEGATIVE = 12'd4095;
    bus.SIN_POSITIVE = 12'd4095;
    bus.ZSPLIT       = 8'd128;
    bus.IN_VALID     = 1'b1;
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_t0", bus.T_0, 0);
    check("arst_t1", bus.T_1, 0);
    check("arst_t2", bus.T_2, 0);
    check("arst_t7", bus.T_7, 0);
    check("arst_rdy", bus.IN_READY, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nvld = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.OUT_VALID) nvld++;
    end
    check("arst_no_vld", nvld, 0);

    request(2048, 2048, 1024, 128, lat);
    expect_res("post_rst", lat, 4, 6250, 5000, 2500, 6250, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ac_motor_svm_dwell.md
# ac_motor_svm_dwell

Parametrised space-vector dwell-time calculator for the AC motor vector modulator. It accepts one sample per request (voltage magnitude and the two sector sine terms) and returns the four switching-period dwell times T_0, T_1, T_2 and T_7 in clock ticks. It adds three things to the fixed 12-bit datapath:
- a valid/ready handshake;
- proportional overmodulation limiting, using a sequential divider;
- a programmable split of the zero-vector time.

It sits between the angle/sine generator and the PWM sequencer.

## Interface
Parameters:
- BITS, 12, width of U_STR, SIN_POSITIVE, SIN_NEGATIVE; full scale is 2^BITS.
- F_CLK, 100000000, clock frequency in Hz.
- F_TAST, 5000, switching frequency in Hz.
- T_TAST, F_CLK/F_TAST (20000), switching period in clocks; must satisfy T_TAST < 2^TW.
- TW, 15, width of the time outputs.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  request strobe.
- IN_READY  out  1  block idle, can accept a request.
- U_STR  in  BITS  voltage magnitude, unsigned fraction of 2^BITS.
- SIN_POSITIVE  in  BITS  sine term for the T_2 vector, unsigned fraction.
- SIN_NEGATIVE  in  BITS  sine term for the T_1 vector, unsigned fraction.
- ZSPLIT  in  8  T_7 share of the zero time, in units of 1/256; 128 gives an even split.
- T_0, T_1, T_2, T_7  out  TW  dwell times in clocks.
- OUT_VALID  out  1  one-cycle result strobe.
- SAT  out  1  the result was overmodulation-limited; held with the outputs.

## Operation
- FSM states: IDLE, MUL, SCALE, CHECK, DIV, ZERO.
- IN_READY = (state == IDLE).
- Transfer: IN_VALID && IN_READY at a rising edge.
  - Registers U_STR, SIN_*, ZSPLIT.
  - IDLE -> MUL.
  - IN_VALID outside IDLE is ignored; no queueing.
- MUL: p1 = U_STR*SIN_NEGATIVE, p2 = U_STR*SIN_POSITIVE, each 2*BITS bits. Go to SCALE.
- SCALE: t1 = (T_TAST*p1) >> (2*BITS), t2 = (T_TAST*p2) >> (2*BITS). Both are truncating; no rounding. Go to CHECK.
- CHECK: s = t1 + t2, TW+1 bits.
  - If s <= T_TAST: tz = T_TAST - s, sat = 0, go to ZERO.
  - Else: sat = 1, go to DIV.
- DIV: restoring divider, exactly TW cycles.
  - Computes t1' = floor(t1*T_TAST / s); numerator 2*TW bits, quotient TW bits.
  - On the last cycle: t1 = t1', t2 = T_TAST - t1', tz = 0. Go to ZERO.
- ZERO: register the outputs, pulse OUT_VALID, SAT = sat, go to IDLE.
  - T_7 = (tz*ZSPLIT) >> 8.
  - T_0 = tz - T_7.
  - T_1 = t1, T_2 = t2.
- Output invariant: T_0 + T_1 + T_2 + T_7 = T_TAST whenever sat = 1, and whenever s <= T_TAST.
- Outputs hold their values until the next ZERO state.
- Width rule: all intermediates are sized so nothing truncates except the stated shifts and the divide.

## Timing
- Reset (async, immediate):
  - state = IDLE, so IN_READY = 1.
  - T_0 = T_1 = T_2 = T_7 = 0, OUT_VALID = 0, SAT = 0.
  - All datapath registers cleared.
- Unsaturated latency: transfer at edge k gives OUT_VALID high for the cycle after edge k+4. IN_READY rises in that same cycle.
- Saturated latency: OUT_VALID is high after edge k+4+TW (19 cycles at TW = 15).
- A new transfer is accepted in the cycle OUT_VALID is high (state is IDLE). Sustained throughput is one result per 5 cycles, or one per 5+TW when saturated.
- RST mid-computation: the computation is aborted, all outputs return to their reset values, and no OUT_VALID is issued.
- Boundary cases:
  - s == T_TAST is not saturated: tz = 0, T_0 = T_7 = 0.
  - ZSPLIT = 0 gives T_7 = 0, T_0 = tz.
  - ZSPLIT = 255 gives T_0 = tz - floor(255*tz/256).

## Test plan
- Reset: assert RST asynchronously between edges -> all outputs 0 immediately; IN_READY = 1 after release.
- Nominal: U = 2048, SIN_NEGATIVE = 2048, SIN_POSITIVE = 1024, ZSPLIT = 128 -> T_1 = 5000, T_2 = 2500, T_0 = 6250, T_7 = 6250, SAT = 0. OUT_VALID arrives 4 cycles after the transfer, for exactly one cycle.
- Overmodulation: U = SIN_NEGATIVE = SIN_POSITIVE = 4095 -> t1 = t2 = 19990 before limiting. Result T_1 = 10000, T_2 = 10000, T_0 = T_7 = 0, SAT = 1, latency 19 cycles.
- Zero split: U = 2048, SIN_NEGATIVE = 2048, SIN_POSITIVE = 1024, ZSPLIT = 0 -> T_7 = 0, T_0 = 12500. With ZSPLIT = 64 -> T_7 = 3125, T_0 = 9375.
- Handshake: hold IN_VALID high continuously with changing data.
  - Only samples present while IN_READY = 1 are processed.
  - Results appear every 5 cycles.
  - A request presented while OUT_VALID is high is accepted.
- Reset mid-DIV: start the overmodulation case, assert RST 8 cycles after the transfer -> no OUT_VALID. The next nominal request returns the correct nominal values.
